// File: rtl/filt_stim_gen.sv
// Stimulus source for the pulse-shaping / matched-filter chain: zero, impulse train,
// step, or PN-driven 4-ASK symbols (held or zero-stuffed), emitted on sam_clk_en.
module filt_stim_gen #(
  parameter int                       WIDTH      = 18,
  parameter logic signed [WIDTH-1:0]  IMP_AMP    = 18'sd131071,
  parameter int                       IMP_PERIOD = 128,
  parameter logic signed [WIDTH-1:0]  LEVEL_HI   = 18'sd98303,
  parameter logic signed [WIDTH-1:0]  LEVEL_LO   = 18'sd32768,
  parameter int                       LFSR_W     = 15,
  parameter logic [LFSR_W-1:0]        TAPS       = 15'h6000,
  parameter logic [LFSR_W-1:0]        SEED       = 15'h0001
) (
  input  logic                    sys_clk,
  input  logic                    rst,
  input  logic                    sam_clk_en,
  input  logic                    sym_clk_en,
  input  logic [1:0]              mode,
  input  logic                    zero_stuff,
  input  logic                    start,
  input  logic                    stop,
  output logic signed [WIDTH-1:0] x_out,
  output logic [1:0]              sym_out,
  output logic                    busy
);

  localparam int CNT_W = $clog2(IMP_PERIOD);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IMP_PERIOD - 1);

  localparam logic [1:0] MODE_ZERO = 2'd0;
  localparam logic [1:0] MODE_IMP  = 2'd1;
  localparam logic [1:0] MODE_STEP = 2'd2;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                  state_reg, state_next;
  logic [1:0]              mode_reg, mode_next;
  logic                    zs_reg, zs_next;
  logic [CNT_W-1:0]        cnt_reg, cnt_next;
  logic [LFSR_W-1:0]       lfsr_reg, lfsr_next, lfsr_step;
  logic [1:0]              sym_reg, sym_next;
  logic signed [WIDTH-1:0] level_reg, level_next, new_level;
  logic                    pend_reg, pend_next;
  logic signed [WIDTH-1:0] x_reg, x_next;

  function automatic logic signed [WIDTH-1:0] level_of(input logic [1:0] sym);
    case (sym)
      2'b00:   return -LEVEL_HI;
      2'b01:   return -LEVEL_LO;
      2'b10:   return LEVEL_LO;
      default: return LEVEL_HI;
    endcase
  endfunction

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_reg <= IDLE;
      mode_reg  <= '0;
      zs_reg    <= 1'b0;
      cnt_reg   <= '0;
      lfsr_reg  <= SEED;
      sym_reg   <= '0;
      level_reg <= '0;
      pend_reg  <= 1'b0;
      x_reg     <= '0;
    end else begin
      state_reg <= state_next;
      mode_reg  <= mode_next;
      zs_reg    <= zs_next;
      cnt_reg   <= cnt_next;
      lfsr_reg  <= lfsr_next;
      sym_reg   <= sym_next;
      level_reg <= level_next;
      pend_reg  <= pend_next;
      x_reg     <= x_next;
    end
  end

  // An all-zero register would lock the PN generator, so it is reseeded instead.
  assign lfsr_step = (lfsr_reg == '0) ? SEED : {lfsr_reg[LFSR_W-2:0], ^(lfsr_reg & TAPS)};
  assign new_level = level_of(lfsr_step[1:0]);

  always_comb begin
    state_next = state_reg;
    mode_next  = mode_reg;
    zs_next    = zs_reg;
    cnt_next   = cnt_reg;
    lfsr_next  = lfsr_reg;
    sym_next   = sym_reg;
    level_next = level_reg;
    pend_next  = pend_reg;
    x_next     = x_reg;

    if (state_reg == IDLE) begin
      x_next = '0;
    end

    if ((state_reg == IDLE && start && !stop) || (state_reg == RUN && start && !stop)) begin
      state_next = RUN;
      mode_next  = mode;
      zs_next    = zero_stuff;
      cnt_next   = '0;
      lfsr_next  = SEED;
      level_next = '0;
      pend_next  = 1'b0;
    end else if (state_reg == RUN && stop) begin
      state_next = IDLE;
      x_next     = '0;
    end else if (state_reg == RUN) begin
      if (sym_clk_en && mode_reg == 2'd3) begin
        lfsr_next  = lfsr_step;
        sym_next   = lfsr_step[1:0];
        level_next = new_level;
        // A symbol without a coincident sample is owed to the next sample.
        pend_next  = !sam_clk_en;
      end
      if (sam_clk_en) begin
        cnt_next = (cnt_reg == CNT_LAST) ? '0 : cnt_reg + 1'b1;
        case (mode_reg)
          MODE_ZERO: x_next = '0;
          MODE_IMP:  x_next = (cnt_reg == '0) ? IMP_AMP : '0;
          MODE_STEP: x_next = IMP_AMP;
          default: begin
            if (sym_clk_en) begin
              x_next = new_level;
            end else if (pend_reg) begin
              x_next    = level_reg;
              pend_next = 1'b0;
            end else begin
              x_next = zs_reg ? '0 : level_reg;
            end
          end
        endcase
      end
    end
  end

  assign x_out   = x_reg;
  assign sym_out = sym_reg;
  assign busy    = (state_reg == RUN);

endmodule

// File: tb/tb_filt_stim_gen.sv
// Bench for filt_stim_gen: per-cycle comparison against a behavioural model plus
// directed sequences with literal expectations.
module tb_filt_stim_gen;

  localparam int P   = 8;
  localparam int AMP = 131071;

  logic        sys_clk = 1'b0;
  logic        rst = 1'b1;
  logic        sam_clk_en = 1'b0;
  logic        sym_clk_en = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic        zero_stuff = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [17:0] x_out, x2;
  logic [1:0]  sym_out, sym2;
  logic        busy, busy2;

  int n_cmp = 0;
  int n_bad = 0;

  filt_stim_gen #(.IMP_PERIOD(P)) dut (
    .sys_clk(sys_clk), .rst(rst), .sam_clk_en(sam_clk_en), .sym_clk_en(sym_clk_en),
    .mode(mode), .zero_stuff(zero_stuff), .start(start), .stop(stop),
    .x_out(x_out), .sym_out(sym_out), .busy(busy)
  );

  // Tap-less instance: the register shifts to all-zero and must reseed.
  filt_stim_gen #(.IMP_PERIOD(P), .TAPS(15'h0000)) dut2 (
    .sys_clk(sys_clk), .rst(rst), .sam_clk_en(sam_clk_en), .sym_clk_en(sym_clk_en),
    .mode(mode), .zero_stuff(zero_stuff), .start(start), .stop(stop),
    .x_out(x2), .sym_out(sym2), .busy(busy2)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model
  int  lv[4] = '{-98303, -32768, 32768, 98303};
  bit  m_run = 0;
  int  m_mode = 0;
  bit  m_zs = 0;
  int  m_n = 0;
  int  m_lfsr = 1;
  int  m_sym = 0;
  int  m_level = 0;
  bit  m_fresh = 0;
  int  m_x = 0;

  function automatic int pn_next(input int q, input int taps);
    if (q == 0) return 1;
    return ((q << 1) | ($countones(q & taps) % 2)) & 32'h7fff;
  endfunction

  initial forever begin
    @(posedge sys_clk);
    if (rst) begin
      m_run = 0; m_x = 0; m_sym = 0; m_lfsr = 1; m_mode = 0; m_zs = 0;
    end else if (start && !stop) begin
      m_run = 1; m_mode = int'(mode); m_zs = zero_stuff; m_n = 0;
      m_lfsr = 1; m_level = 0; m_fresh = 0;
    end else if (m_run && stop) begin
      m_run = 0; m_x = 0;
    end else if (m_run) begin
      if (sym_clk_en && m_mode == 3) begin
        m_lfsr  = pn_next(m_lfsr, 'h6000);
        m_sym   = m_lfsr % 4;
        m_level = lv[m_sym];
        m_fresh = 1;
      end
      if (sam_clk_en) begin
        case (m_mode)
          0: m_x = 0;
          1: m_x = (m_n % P == 0) ? AMP : 0;
          2: m_x = AMP;
          default: begin
            m_x = (m_fresh || !m_zs) ? m_level : 0;
            m_fresh = 0;
          end
        endcase
        m_n++;
      end
    end
  end

  initial forever begin
    @(negedge sys_clk);
    chk("model_x", int'($signed(x_out)), m_x);
    chk("model_sym", int'(sym_out), m_sym);
    chk("model_busy", int'(busy), int'(m_run));
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic pulse_start(input logic [1:0] md, input logic zs);
    mode = md; zero_stuff = zs; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic sample(input logic sym);
    sam_clk_en = 1'b1; sym_clk_en = sym;
    tick();
    sam_clk_en = 1'b0; sym_clk_en = 1'b0;
    tick();
  endtask

  initial begin
    int ex;
    // 1: reset and idle
    repeat (4) tick();
    rst = 1'b0;
    repeat (50) tick();
    chk("idle_x", int'($signed(x_out)), 0);
    chk("idle_busy", int'(busy), 0);
    chk("idle_sym", int'(sym_out), 0);

    // 2: impulse train of period 8
    pulse_start(2'd1, 1'b0);
    chk("imp_busy", int'(busy), 1);
    for (int k = 0; k < 17; k++) begin
      sample(1'b0);
      chk($sformatf("imp_x%0d", k), int'($signed(x_out)), (k % 8 == 0) ? AMP : 0);
    end

    // 3: 4-ASK held; mode change mid-run must be ignored
    pulse_start(2'd3, 1'b0);
    mode = 2'd0;
    for (int k = 0; k < 8; k++) begin
      sample(k % 4 == 0);
      chk($sformatf("hold_x%0d", k), int'($signed(x_out)), (k < 4) ? 32768 : -98303);
      chk($sformatf("hold_sym%0d", k), int'(sym_out), (k < 4) ? 2 : 0);
    end

    // 4: 4-ASK zero-stuffed, then a symbol without a sample
    pulse_start(2'd3, 1'b1);
    for (int k = 0; k < 8; k++) begin
      sample(k % 4 == 0);
      ex = (k % 4 != 0) ? 0 : ((k < 4) ? 32768 : -98303);
      chk($sformatf("zs_x%0d", k), int'($signed(x_out)), ex);
    end
    sym_clk_en = 1'b1;
    tick();
    sym_clk_en = 1'b0;
    chk("mis_sym", int'(sym_out), 0);
    sample(1'b0);
    chk("mis_x_late", int'($signed(x_out)), -98303);
    sample(1'b0);
    chk("mis_x_zero", int'($signed(x_out)), 0);

    // 5: start with stop -> stop wins; fresh start restarts the sequence
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("ss_busy", int'(busy), 0);
    chk("ss_x", int'($signed(x_out)), 0);
    repeat (3) tick();
    pulse_start(2'd3, 1'b0);
    sample(1'b1);
    chk("rs_sym", int'(sym_out), 2);
    chk("rs_x", int'($signed(x_out)), 32768);

    // 6: reset mid-run in step mode
    pulse_start(2'd2, 1'b0);
    sample(1'b0);
    chk("step_x", int'($signed(x_out)), AMP);
    rst = 1'b1;
    tick();
    chk("rst_x", int'($signed(x_out)), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_sym", int'(sym_out), 0);
    rst = 1'b0;
    pulse_start(2'd3, 1'b0);
    sample(1'b1);
    chk("seed_sym", int'(sym_out), 2);

    // Lock-up reseed on the tap-less instance: 1<<15 truncates to zero
    pulse_start(2'd3, 1'b0);
    for (int k = 1; k <= 17; k++) begin
      sample(1'b1);
      if (k == 15) chk("lock_sym15", int'(sym2), 0);
      if (k == 16) begin
        chk("lock_sym16", int'(sym2), 1);
        chk("lock_x16", int'($signed(x2)), -32768);
      end
      if (k == 17) chk("lock_sym17", int'(sym2), 2);
    end
    chk("lock_busy", int'(busy2), 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/filt_stim_gen.md
Name: filt_stim_gen

Overview:
- Synthesizable, parametrised stimulus source for the pulse-shaping and matched-filter chain.
- Produces signed 1s17 samples on `sam_clk_en` for a filter's `x_in`, in one of four run-time modes:
  - zero
  - periodic impulse
  - step
  - PN-driven 4-ASK symbols, held or zero-stuffed
- Sits between the `clk_en` block and any filter DUT, on the bench or on the board.

Parameters:
- WIDTH, 18, sample width (signed, 1sWIDTH-1 format).
- IMP_AMP, 18'sd131071, impulse and step amplitude.
- IMP_PERIOD, 128, sample period of the impulse train (at least 2).
- LEVEL_HI, 18'sd98303, outer 4-ASK magnitude.
- LEVEL_LO, 18'sd32768, inner 4-ASK magnitude.
- LFSR_W, 15, PN register width.
- TAPS, 15'h6000, feedback tap mask (bit i set means q[i] is XORed into feedback).
- SEED, 15'h0001, LFSR reset/reload value (nonzero).

Ports:
- sys_clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- sam_clk_en  in  1  sample-rate enable, one `sys_clk` wide
- sym_clk_en  in  1  symbol-rate enable; coincides with a `sam_clk_en` cycle
- mode  in  2  0=zero, 1=impulse, 2=step, 3=4-ASK
- zero_stuff  in  1  4-ASK only: 1 means symbol on symbol sample and zeros elsewhere; 0 means hold
- start  in  1  single-cycle pulse: latch mode, begin or restart run
- stop  in  1  single-cycle pulse: end run
- x_out  out  WIDTH  signed sample to filter
- sym_out  out  2  current 4-ASK symbol index
- busy  out  1  high while in RUN

Behaviour:
- Clock and reset: all state on posedge `sys_clk`. Reset has priority over everything.
- Reset values: x_out=0, sym_out=0, busy=0, state IDLE, lfsr=SEED, sam_cnt=0, mode_r=0, zs_r=0.
- FSM has two states, IDLE and RUN.
  - IDLE, start=1: mode_r<=mode, zs_r<=zero_stuff, sam_cnt<=0, lfsr<=SEED, go to RUN.
  - RUN, stop=1: go to IDLE and x_out<=0 on that edge.
  - RUN, start=1 with stop=0: restart. Re-latch mode and zero_stuff, sam_cnt<=0, lfsr<=SEED, stay in RUN.
  - start and stop together: stop wins.
  - `mode` and `zero_stuff` changes while in RUN are ignored until the next start.
- busy: 1 exactly while in RUN.
- x_out updates only on edges with sam_clk_en=1 and state RUN. It is registered one `sys_clk` after the enable and otherwise holds.
- In IDLE, x_out is 0.
- Mode 0: x_out<=0.
- Mode 1, impulse:
  - x_out<=IMP_AMP when sam_cnt==0, else 0.
  - sam_cnt increments per sam_clk_en and wraps IMP_PERIOD-1 to 0.
  - The first sample after start is IMP_AMP.
- Mode 2, step: x_out<=IMP_AMP on every sam_clk_en.
- Mode 3, 4-ASK:
  - LFSR update on each sym_clk_en in RUN: lfsr<={lfsr[LFSR_W-2:0], ^(lfsr & TAPS)}.
  - Symbol index is next-lfsr[1:0], registered into sym_out on the same edge.
  - Level map: 00 to -LEVEL_HI, 01 to -LEVEL_LO, 10 to +LEVEL_LO, 11 to +LEVEL_HI.
  - On a sam_clk_en that coincides with sym_clk_en, x_out<=the new symbol's level.
  - On other sam_clk_en: x_out<=0 if zs_r, else hold the last level.
  - If sym_clk_en arrives without sam_clk_en (enable misalignment): sym_out and lfsr still update, and the level appears at the next sam_clk_en.
- LFSR lock-up: if lfsr==0 at an update, reload SEED instead of shifting.
- Arithmetic: negation is in WIDTH-bit two's complement. Level parameters must be at most 2^(WIDTH-1)-1, so no saturation logic is needed.
- Reset mid-run: returns to IDLE on the same edge with all outputs at reset values. No sample is emitted on that edge.

Test Plan:
1. rst high for 4 cycles, then idle 50 cycles -> x_out=0, busy=0, sym_out=0 throughout.
2. mode=1, IMP_PERIOD=8, start -> on successive sam_clk_en x_out = 131071, then 0 for seven samples, then 131071 again. busy=1.
3. mode=3, zero_stuff=0, SEED=1, sym_clk_en every 4th sam_clk_en, start -> first symbols:
   - lfsr 0x0002, sym_out=2, x_out=+32768 held for 4 samples;
   - then lfsr 0x0004, sym_out=0, x_out=-98303.
4. Same as scenario 3 with zero_stuff=1 -> x_out = +32768, 0, 0, 0, then -98303, 0, 0, 0.
5. In RUN, mode=3: pulse start and stop in the same cycle -> IDLE, x_out=0 next edge. Later, start alone -> sequence restarts from lfsr 0x0002.
6. Assert rst mid-run in mode 2 (x_out=131071) -> next edge x_out=0, busy=0, lfsr=SEED. Also force lfsr=0 -> next sym_clk_en reloads 0x0001.
